// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller at M: SR/Cause/EPC/PRId, mfc0/mtc0, eret EPC.
// req and cp0_rdata are combinational (zero latency); register updates land at the next edge; no backpressure.
module cp0_exc_ctrl #(
   parameter logic [31:0] PRID_VAL = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   output logic [31:0] cp0_rdata,
   input  logic [31:0] vpc,
   input  logic        bd_in,
   input  logic [4:0]  exc_code_in,
   input  logic [5:0]  hw_int,
   input  logic        exl_clr,
   output logic [31:0] epc_out,
   output logic        req
);

   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;
   localparam logic [4:0] ADDR_PRID  = 5'd15;

   logic [5:0]  im;
   logic        exl;
   logic        ie;
   logic        bd;
   logic [5:0]  ip;
   logic [4:0]  exc_code;
   logic [31:0] epc;

   logic        int_req;
   logic        exc_req;
   logic [31:0] sr;
   logic [31:0] cause;

   assign int_req = (|(hw_int & im)) & ie & ~exl;
   assign exc_req = (exc_code_in != 5'd0) & ~exl;
   assign req     = int_req | exc_req;

   assign sr      = {16'd0, im, 8'd0, exl, ie};
   assign cause   = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
   assign epc_out = epc;

   always_ff @(posedge clk) begin
      if (reset) begin
         im       <= 6'd0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         ip       <= 6'd0;
         exc_code <= 5'd0;
         epc      <= 32'd0;
      end else begin
         ip <= hw_int;
         if (req) begin
            // Taking the trap discards any same-cycle mtc0 and eret.
            exl      <= 1'b1;
            exc_code <= int_req ? 5'd0 : exc_code_in;
            bd       <= bd_in;
            epc      <= bd_in ? (vpc - 32'd4) : vpc;
         end else begin
            if (en && cp0_addr == ADDR_SR) begin
               im  <= cp0_wdata[15:10];
               exl <= cp0_wdata[1];
               ie  <= cp0_wdata[0];
            end
            if (en && cp0_addr == ADDR_EPC) begin
               epc <= cp0_wdata;
            end
            // Placed after the SR write so eret's clear overrides it.
            if (exl_clr) begin
               exl <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      cp0_rdata = 32'd0;
      case (cp0_addr)
         ADDR_SR:    cp0_rdata = sr;
         ADDR_CAUSE: cp0_rdata = cause;
         ADDR_EPC:   cp0_rdata = epc;
         ADDR_PRID:  cp0_rdata = PRID_VAL;
         default:    cp0_rdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl with hand-computed expectations.
module tb_cp0_exc_ctrl;

   localparam logic [31:0] PRID = 32'h00C0_FFEE;

   logic        clk;
   logic        reset;
   logic        en;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic [31:0] cp0_rdata;
   logic [31:0] vpc;
   logic        bd_in;
   logic [4:0]  exc_code_in;
   logic [5:0]  hw_int;
   logic        exl_clr;
   logic [31:0] epc_out;
   logic        req;

   int n_checks;
   int n_fail;

   cp0_exc_ctrl #(.PRID_VAL(PRID)) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .cp0_addr    (cp0_addr),
      .cp0_wdata   (cp0_wdata),
      .cp0_rdata   (cp0_rdata),
      .vpc         (vpc),
      .bd_in       (bd_in),
      .exc_code_in (exc_code_in),
      .hw_int      (hw_int),
      .exl_clr     (exl_clr),
      .epc_out     (epc_out),
      .req         (req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
      cp0_addr = addr;
      #1;
      check(tag, cp0_rdata, exp);
   endtask

   task automatic chk_req(input logic exp, input string tag);
      #1;
      check(tag, {31'd0, req}, {31'd0, exp});
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      reset       = 1'b1;
      en          = 1'b0;
      cp0_addr    = 5'd0;
      cp0_wdata   = 32'd0;
      vpc         = 32'd0;
      bd_in       = 1'b0;
      exc_code_in = 5'd0;
      hw_int      = 6'd0;
      exl_clr     = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // 1: reset state
      hw_int = 6'h3F;
      rd(5'd12, 32'h0, "rst_sr");
      rd(5'd13, 32'h0, "rst_cause");
      rd(5'd14, 32'h0, "rst_epc");
      rd(5'd15, PRID, "rst_prid");
      rd(5'd3, 32'h0, "rd_other");
      chk_req(1'b0, "rst_req_ie0");
      hw_int = 6'd0;

      // 2: interrupt
      en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC01;
      tick();
      en = 1'b0;
      rd(5'd12, 32'h0000_FC01, "sr_write");
      hw_int = 6'b000001; vpc = 32'h0000_3000; bd_in = 1'b0;
      chk_req(1'b1, "int_req");
      tick();
      rd(5'd12, 32'h0000_FC03, "int_sr");
      rd(5'd13, 32'h0000_0400, "int_cause");
      check("int_epc", epc_out, 32'h0000_3000);
      chk_req(1'b0, "int_exl_mask");
      hw_int = 6'd0;
      en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0;
      tick();
      en = 1'b0;
      rd(5'd12, 32'h0, "sr_clear");

      // 3: RI exception in delay slot
      exc_code_in = 5'd10; bd_in = 1'b1; vpc = 32'h0000_3010;
      chk_req(1'b1, "exc_req");
      tick();
      exc_code_in = 5'd0; bd_in = 1'b0;
      rd(5'd14, 32'h0000_300C, "exc_epc_bd");
      rd(5'd13, 32'h8000_0028, "exc_cause");
      rd(5'd12, 32'h0000_0002, "exc_sr");

      // eret alongside an SR write that sets EXL: EXL still ends at 0
      exl_clr = 1'b1; en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC03;
      tick();
      exl_clr = 1'b0; en = 1'b0;
      rd(5'd12, 32'h0000_FC01, "sr_wr_then_clr");

      // 4: interrupt beats exception; same-cycle mtc0 EPC dropped
      hw_int = 6'b000100; exc_code_in = 5'd8; vpc = 32'h0000_4000; bd_in = 1'b0;
      en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_1234;
      chk_req(1'b1, "both_req");
      tick();
      en = 1'b0; exc_code_in = 5'd0;
      rd(5'd13, 32'h0000_1000, "both_cause");
      rd(5'd14, 32'h0000_4000, "both_epc");
      check("both_epc_out", epc_out, 32'h0000_4000);

      // 5: masked while EXL, then eret re-enables the pending interrupt
      exc_code_in = 5'd4;
      chk_req(1'b0, "exl_blocks_exc");
      tick();
      exc_code_in = 5'd0;
      rd(5'd13, 32'h0000_1000, "exl_cause_kept");
      exl_clr = 1'b1;
      chk_req(1'b0, "exl_clr_req");
      tick();
      exl_clr = 1'b0;
      rd(5'd12, 32'h0000_FC01, "eret_sr");
      vpc = 32'h0; bd_in = 1'b1;
      chk_req(1'b1, "pending_int_req");
      tick();
      bd_in = 1'b0;
      check("epc_wrap", epc_out, 32'hFFFF_FFFC);
      rd(5'd13, 32'h8000_1000, "wrap_cause");

      // 6: Cause not writable, EPC written with no bypass
      hw_int = 6'b100000;
      en = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
      tick();
      cp0_addr = 5'd15;
      tick();
      en = 1'b0;
      rd(5'd13, 32'h8000_8000, "cause_ro");
      rd(5'd15, PRID, "prid_ro");
      en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'hDEAD_BEEC;
      #1;
      check("epc_no_bypass", cp0_rdata, 32'hFFFF_FFFC);
      tick();
      en = 1'b0;
      check("epc_mtc0", epc_out, 32'hDEAD_BEEC);

      // reset wins over a same-cycle request
      exl_clr = 1'b1;
      tick();
      exl_clr = 1'b0;
      exc_code_in = 5'd3; reset = 1'b1;
      chk_req(1'b1, "req_before_rst");
      tick();
      reset = 1'b0; exc_code_in = 5'd0;
      rd(5'd12, 32'h0, "rst_win_sr");
      rd(5'd13, 32'h0, "rst_win_cause");
      check("rst_win_epc", epc_out, 32'h0);

      // eret in the trap cycle is ignored
      hw_int = 6'd0; exc_code_in = 5'd5; exl_clr = 1'b1; vpc = 32'h0000_0040;
      tick();
      exc_code_in = 5'd0; exl_clr = 1'b0;
      rd(5'd12, 32'h0000_0002, "trap_beats_eret");
      rd(5'd13, 32'h0000_0014, "trap_cause5");
      check("trap_epc", epc_out, 32'h0000_0040);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
